// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions for the TX and RX engines. Holds the
//                frame-state encodings, parity mode constants and a small
//                width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame states (3-bit; encodings 5..7 are illegal and recover to IDLE)
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // Parity mode as carried on par_odd
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // $clog2 that never returns zero, so a counter of one state still has a bit
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Bit-period counter shared by the UART TX and RX engines.
//                Counts 0..CLKS_PER_BIT-1 and wraps; bit_end marks the last
//                cycle of each bit period. bit_end_next predicts bit_end for
//                the following cycle so that users can register it.
//  Ports       : clk          - clock, rising edge
//                rstn         - asynchronous active-low reset
//                clear        - hold the counter at zero
//                bit_end      - current cycle is the last of the bit period
//                bit_end_next - next cycle will be the last of the bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic bit_end,
  output logic bit_end_next
);

  localparam int              CNT_W    = clog2_min1(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  // Only meaningful when CLKS_PER_BIT >= 2; the single-cycle case short-cuts it
  localparam logic [CNT_W-1:0] C_PENULT = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic             C_SINGLE = (CLKS_PER_BIT == 1);

  logic [CNT_W-1:0] r_cnt;

  assign bit_end = (r_cnt == C_LAST);

  // After a clear or a wrap the counter restarts at 0, which is a bit end only
  // when every cycle is its own bit period.
  assign bit_end_next = C_SINGLE | (~clear & ~bit_end & (r_cnt == C_PENULT));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clear || bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_core
//  Description : UART transmit engine. Frame FSM, serializer and parity
//                generator around a shared bit timer. One word is taken per
//                data_valid/ready handshake and sent as start, DATA_W data bits
//                LSB first, optional parity, then 1 or 2 stop bits.
//  Ports       : clk, rstn   - clock / asynchronous active-low reset
//                data_in     - word to send, sampled on accept
//                data_valid  - host has a word
//                ready       - core accepts this cycle (combinational)
//                par_en      - append parity bit (sampled on accept)
//                par_odd     - 0 even / 1 odd parity (sampled on accept)
//                stop2       - two stop bits (sampled on accept)
//                tx_out      - registered serial line, idle high
//                busy        - registered, high while a frame is on the line
//                done        - registered pulse in the last frame cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              ready,
  input  logic              par_en,
  input  logic              par_odd,
  input  logic              stop2,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int                   BIT_IDX_W  = clog2_min1(DATA_W);
  localparam logic [BIT_IDX_W-1:0] C_LAST_BIT = BIT_IDX_W'(DATA_W - 1);

  logic [2:0]           r_state;
  logic [DATA_W-1:0]    r_shift;
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic                 r_stop_idx;
  logic                 r_par_en;
  logic                 r_stop2;
  logic                 r_parity;
  logic                 r_tx_out;
  logic                 r_busy;
  logic                 r_done;

  logic [2:0]           w_state_nxt;
  logic [DATA_W-1:0]    w_shift_nxt;
  logic [BIT_IDX_W-1:0] w_bit_idx_nxt;
  logic                 w_stop_idx_nxt;
  logic                 w_par_en_nxt;
  logic                 w_stop2_nxt;
  logic                 w_parity_nxt;
  logic                 w_tx_nxt;
  logic                 w_done_nxt;
  logic                 w_load;
  logic                 w_par_calc;
  logic                 w_bit_end;
  logic                 w_bit_end_next;
  logic                 w_last_stop;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_timer_clr;

  // The timer idles at zero so the start bit gets a full period after accept
  assign w_timer_clr = (r_state == IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk          (clk),
    .rstn         (rstn),
    .clear        (w_timer_clr),
    .bit_end      (w_bit_end),
    .bit_end_next (w_bit_end_next)
  );

  // r_stop_idx counts stop bits already completed; the last one is reached
  // when it equals the latched stop2 (0 for one stop bit, 1 for two).
  assign w_last_stop = (r_stop_idx == r_stop2);
  assign w_ready     = (r_state == IDLE) |
                       ((r_state == STOP) & w_last_stop & w_bit_end);
  assign w_accept    = data_valid & w_ready;
  assign ready       = w_ready;

  always_comb begin
    w_par_calc = 1'b0;
    case (par_odd)
      PAR_EVEN: w_par_calc = ^data_in;
      PAR_ODD:  w_par_calc = ~^data_in;
      default:  w_par_calc = 1'b0;
    endcase
  end

  // Next-state logic. A load (from IDLE, or straight out of the last stop bit
  // for back-to-back frames) captures the word and its framing options.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_par_en_nxt   = r_par_en;
    w_stop2_nxt    = r_stop2;
    w_parity_nxt   = r_parity;
    w_load         = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) w_load = 1'b1;
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt   = DATA;
          w_bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == C_LAST_BIT) begin
            w_state_nxt    = r_par_en ? PARITY : STOP;
            w_stop_idx_nxt = 1'b0;
          end else begin
            w_shift_nxt   = {1'b0, r_shift[DATA_W-1:1]};
            w_bit_idx_nxt = r_bit_idx + BIT_IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt    = STOP;
          w_stop_idx_nxt = 1'b0;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (!w_last_stop) begin
            w_stop_idx_nxt = 1'b1;
          end else if (w_accept) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_load) begin
      w_state_nxt    = START;
      w_shift_nxt    = data_in;
      w_bit_idx_nxt  = '0;
      w_stop_idx_nxt = 1'b0;
      w_par_en_nxt   = par_en;
      w_stop2_nxt    = stop2;
      w_parity_nxt   = w_par_calc;
    end
  end

  // Outputs are registered from the next state so they line up with it
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      PARITY:  w_tx_nxt = w_parity_nxt;
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // done lands on the final cycle of the last stop bit
  assign w_done_nxt = (w_state_nxt == STOP) &
                      (w_stop_idx_nxt == w_stop2_nxt) &
                      w_bit_end_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_parity   <= 1'b0;
      r_tx_out   <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_par_en   <= w_par_en_nxt;
      r_stop2    <= w_stop2_nxt;
      r_parity   <= w_parity_nxt;
      r_tx_out   <= w_tx_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= w_done_nxt;
    end
  end

  assign tx_out = r_tx_out;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_core
//  Description : Scoreboard bench for uart_tx_core (DATA_W=8, CLKS_PER_BIT=16).
//                The driver queues each expected frame when the handshake
//                completes; the monitor decodes tx_out/busy/done/ready frames
//                and compares them against the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_core;

  localparam int DATA_W = 8;
  localparam int CPB    = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              ready;
  logic              par_en;
  logic              par_odd;
  logic              stop2;
  logic              tx_out;
  logic              busy;
  logic              done;

  uart_tx_core #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .data_in    (data_in),
    .data_valid (data_valid),
    .ready      (ready),
    .par_en     (par_en),
    .par_odd    (par_odd),
    .stop2      (stop2),
    .tx_out     (tx_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pb;   // expected parity bit, hand computed
    logic       s2;
    int         acc;  // cycle count at the accepting edge
    bit         ab;   // frame is expected to be cut by reset
  } frame_t;

  frame_t q[$];
  int     n_checks = 0;
  int     n_err    = 0;
  int     idle_bad = 0;
  bit     mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, got, got, exp, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    frame_t rec;
    logic   bits[12];
    int     okc[12];
    int     nb, len, bi, busy_ok, done_ok, ready_ok;
    bit     aborted;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) continue;
      if (tx_out !== 1'b0) begin
        if (busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) idle_bad++;
        continue;
      end
      mon_busy = 1'b1;
      check("frame_was_queued", (q.size() > 0), 1);
      if (q.size() == 0) begin
        for (int i = 0; i < 5000 && !(tx_out === 1'b1 && busy === 1'b0); i++) @(negedge clk);
        mon_busy = 1'b0;
        continue;
      end
      rec = q.pop_front();
      check($sformatf("start_cycle_%02h", rec.data), cyc, rec.acc);
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = rec.data[i];
      nb = 9;
      if (rec.pe) begin bits[nb] = rec.pb; nb++; end
      bits[nb] = 1'b1; nb++;
      if (rec.s2) begin bits[nb] = 1'b1; nb++; end
      len = nb * CPB;
      foreach (okc[i]) okc[i] = 0;
      busy_ok = 0; done_ok = 0; ready_ok = 0; aborted = 1'b0;
      for (int c = 0; c < len; c++) begin
        if (c > 0) @(negedge clk);
        if (rstn !== 1'b1) begin aborted = 1'b1; break; end
        bi = c / CPB;
        if (tx_out === bits[bi])        okc[bi]++;
        if (busy === 1'b1)              busy_ok++;
        if (done === (c == len - 1))    done_ok++;
        if (ready === (c == len - 1))   ready_ok++;
        if (c % CPB == CPB - 1)
          check($sformatf("frame_%02h_bit%0d_cycles", rec.data, bi), okc[bi], CPB);
      end
      if (aborted) begin
        check($sformatf("frame_%02h_reset_abort_allowed", rec.data), rec.ab, 1);
      end else begin
        check($sformatf("frame_%02h_busy_cycles", rec.data), busy_ok, len);
        check($sformatf("frame_%02h_done_cycles", rec.data), done_ok, len);
        check($sformatf("frame_%02h_ready_cycles", rec.data), ready_ok, len);
      end
      mon_busy = 1'b0;
    end
  end

  // ----------------------------------------------------------------- driver
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input logic pe, input logic po,
                      input logic s2, input logic exp_par, input bit ab);
    frame_t r;
    bit     got;
    data_in = d; par_en = pe; par_odd = po; stop2 = s2; data_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (ready === 1'b1) begin
        r.data = d; r.pe = pe; r.pb = exp_par; r.s2 = s2;
        r.acc = cyc + 1; r.ab = ab;
        q.push_back(r);
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("accept_%02h_in_bound", d), got, 1);
    @(negedge clk);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (q.size() == 0 && !mon_busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("drain_in_bound", ok, 1);
  endtask

  task automatic toggle_inputs(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_valid = 1'b1;
      data_in    = i[0] ? 8'hFF : 8'h00;
      par_en     = i[0];
      par_odd    = ~i[1];
      stop2      = ~i[0];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_out"}, tx_out, 1);
    check({tag, "_busy"},   busy,   0);
    check({tag, "_done"},   done,   0);
    check({tag, "_ready"},  ready,  1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------- stimulus
  initial begin : stimulus
    rstn = 1'b0; data_valid = 1'b1; data_in = 8'hA5;
    par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;

    // 1: held in reset with a word offered; nothing may start
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_reset_outputs("in_reset");
    end
    rstn = 1'b1;

    // 2: 0xA5, 8N1, 160-cycle frame
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    data_valid = 1'b0;
    drain();

    // 3: 0x07 with even parity (bit 1), then odd parity (bit 0)
    send(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    data_valid = 1'b0;
    drain();
    send(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    data_valid = 1'b0;
    drain();

    // 4: two stop bits, valid held across back-to-back frames
    send(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    data_valid = 1'b0;
    drain();

    // 5a: inputs churn mid-frame, valid withdrawn before ready -> no extra frame
    send(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    toggle_inputs(60);
    data_valid = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    check("no_stale_frame_busy", busy, 0);

    // 5b: churn then 0xFF still valid at ready -> sent back-to-back, odd parity 1
    send(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    toggle_inputs(60);
    send(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    data_valid = 1'b0;
    drain();

    // 6: reset during data bit 3 (a 0 bit), then a clean frame
    send(8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    data_valid = 1'b0;
    repeat (70) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #2 rstn = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    drain();
    repeat (5) @(negedge clk);
    send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    data_valid = 1'b0;
    drain();

    repeat (10) @(negedge clk);
    check("idle_cycles_with_bad_outputs", idle_bad, 0);
    check("scoreboard_left_over", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
